// File: rtl/ex_ma_elastic_reg.sv
// EX->MA pipeline register with valid/ready handshake, flush and bubble masking.
// With SKID=1 a second entry absorbs the in-flight instruction when MA stalls, so
// in_ready is a pure flop output; with SKID=0 it is a single register whose ready
// depends combinationally on out_ready.
module ex_ma_elastic_reg #(
    parameter int unsigned CTRL_W = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned F3_W   = 3,
    parameter int unsigned RD_W   = 5,
    parameter int unsigned SKID   = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FLUSH,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_data2,
    input  logic [F3_W-1:0]   in_func3,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_data2,
    output logic [F3_W-1:0]   out_func3,
    output logic [RD_W-1:0]   out_rd
);

    localparam int unsigned PW = CTRL_W + 2 * DATA_W + F3_W + RD_W;

    logic [PW-1:0]     in_pay;
    logic [PW-1:0]     main_q, main_d;
    logic [PW-1:0]     skid_q, skid_d;
    logic              main_v_q, main_v_d;
    logic              skid_v_q, skid_v_d;
    logic              accept;
    logic              consume;
    logic [CTRL_W-1:0] main_ctrl;

    assign in_pay  = {in_ctrl, in_alu, in_data2, in_func3, in_rd};
    assign in_ready = (SKID != 0) ? !skid_v_q : (!main_v_q || out_ready);
    assign accept  = in_valid && in_ready;
    assign consume = main_v_q && out_ready;

    // Next-state for the main/skid entries; the skid entry is always the younger one.
    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        if (FLUSH) begin
            // Payload keeps its old value; only the valid bits matter after a kill.
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (SKID != 0) begin
            case ({main_v_q, skid_v_q})
                2'b00: begin
                    if (accept) begin
                        main_d   = in_pay;
                        main_v_d = 1'b1;
                    end
                end
                2'b10: begin
                    if (accept && consume) begin
                        main_d = in_pay;
                    end else if (accept) begin
                        skid_d   = in_pay;
                        skid_v_d = 1'b1;
                    end else if (consume) begin
                        main_v_d = 1'b0;
                    end
                end
                2'b11: begin
                    if (consume) begin
                        main_d   = skid_q;
                        skid_v_d = 1'b0;
                    end
                end
                default: begin
                    // {0,1} is unreachable: skid only fills behind a valid main entry.
                    skid_v_d = 1'b0;
                end
            endcase
        end else begin
            if (accept) begin
                main_d   = in_pay;
                main_v_d = 1'b1;
            end else if (consume) begin
                main_v_d = 1'b0;
            end
        end
    end

    // State registers; synchronous reset wins over flush and handshakes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
        end else begin
            main_q   <= main_d;
            skid_q   <= skid_d;
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
        end
    end

    // Output unpacking; control is masked so a bubble never writes memory or registers.
    always_comb begin
        {main_ctrl, out_alu, out_data2, out_func3, out_rd} = main_q;
        out_valid = main_v_q;
        out_ctrl  = main_ctrl & {CTRL_W{main_v_q}};
    end

endmodule

// File: tb/tb_ex_ma_elastic_reg.sv
// Bench for ex_ma_elastic_reg: one SKID=1 and one SKID=0 instance, each with a
// scoreboard queue filled by the stimulus and drained by an output monitor.
module tb_ex_ma_elastic_reg;

    localparam int PW = 4 + 32 + 32 + 3 + 5;
    typedef logic [PW-1:0] pay_t;

    logic CLK = 1'b0;
    logic RESET, FLUSH;

    // SKID=1 instance signals
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  in_ctrl, out_ctrl;
    logic [31:0] in_alu, in_data2, out_alu, out_data2;
    logic [2:0]  in_func3, out_func3;
    logic [4:0]  in_rd, out_rd;

    // SKID=0 instance signals
    logic        s0_in_valid, s0_in_ready, s0_out_valid, s0_out_ready;
    logic [3:0]  s0_in_ctrl, s0_out_ctrl;
    logic [31:0] s0_in_alu, s0_in_data2, s0_out_alu, s0_out_data2;
    logic [2:0]  s0_in_func3, s0_out_func3;
    logic [4:0]  s0_in_rd, s0_out_rd;

    int   n_checks = 0;
    int   n_errors = 0;
    pay_t q1[$];
    pay_t q0[$];
    pay_t pay1, pay0;

    always #5 CLK = ~CLK;

    ex_ma_elastic_reg #(.SKID(1)) dut (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_alu(in_alu), .in_data2(in_data2),
        .in_func3(in_func3), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_alu(out_alu), .out_data2(out_data2),
        .out_func3(out_func3), .out_rd(out_rd)
    );

    ex_ma_elastic_reg #(.SKID(0)) dut0 (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
        .in_valid(s0_in_valid), .in_ready(s0_in_ready),
        .in_ctrl(s0_in_ctrl), .in_alu(s0_in_alu), .in_data2(s0_in_data2),
        .in_func3(s0_in_func3), .in_rd(s0_in_rd),
        .out_valid(s0_out_valid), .out_ready(s0_out_ready),
        .out_ctrl(s0_out_ctrl), .out_alu(s0_out_alu), .out_data2(s0_out_data2),
        .out_func3(s0_out_func3), .out_rd(s0_out_rd)
    );

    assign pay1 = {out_ctrl, out_alu, out_data2, out_func3, out_rd};
    assign pay0 = {s0_out_ctrl, s0_out_alu, s0_out_data2, s0_out_func3, s0_out_rd};

    function automatic void chk(input string name, input pay_t act, input pay_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor, SKID=1: held output must equal queue head; pop on consume.
    always @(negedge CLK) begin
        if (out_valid === 1'b1) begin
            if (q1.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL skid unexpected output: got %0h expected none", pay1);
            end else begin
                chk(out_ready === 1'b1 ? "skid consume" : "skid stall hold", pay1, q1[0]);
                if (out_ready === 1'b1) void'(q1.pop_front());
            end
        end else if (out_valid === 1'b0) begin
            chk("skid bubble ctrl", pay_t'(out_ctrl), '0);
        end
    end

    // Monitor, SKID=0.
    always @(negedge CLK) begin
        if (s0_out_valid === 1'b1) begin
            if (q0.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL noskid unexpected output: got %0h expected none", pay0);
            end else begin
                chk(s0_out_ready === 1'b1 ? "noskid consume" : "noskid stall hold", pay0, q0[0]);
                if (s0_out_ready === 1'b1) void'(q0.pop_front());
            end
        end else if (s0_out_valid === 1'b0) begin
            chk("noskid bubble ctrl", pay_t'(s0_out_ctrl), '0);
        end
    end

    task automatic send1(input logic v, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] f, input logic [4:0] r,
                         input logic push);
        in_valid = v; in_ctrl = c; in_alu = a; in_data2 = d; in_func3 = f; in_rd = r;
        if (push) q1.push_back({c, a, d, f, r});
    endtask

    task automatic send0(input logic v, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] f, input logic [4:0] r,
                         input logic push);
        s0_in_valid = v; s0_in_ctrl = c; s0_in_alu = a; s0_in_data2 = d;
        s0_in_func3 = f; s0_in_rd = r;
        if (push) q0.push_back({c, a, d, f, r});
    endtask

    task automatic cyc1(input string name, input logic exp_rdy, input logic exp_ov);
        @(negedge CLK);
        chk({name, " in_ready"}, pay_t'(in_ready), pay_t'(exp_rdy));
        chk({name, " out_valid"}, pay_t'(out_valid), pay_t'(exp_ov));
        @(posedge CLK);
        #1;
    endtask

    task automatic cyc0(input string name, input logic exp_rdy, input logic exp_ov);
        @(negedge CLK);
        chk({name, " in_ready"}, pay_t'(s0_in_ready), pay_t'(exp_rdy));
        chk({name, " out_valid"}, pay_t'(s0_out_valid), pay_t'(exp_ov));
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // T1: reset with in_valid high
        RESET = 1'b1; FLUSH = 1'b0; out_ready = 1'b0; s0_out_ready = 1'b0;
        send1(1'b1, 4'hF, 32'h99, 32'h98, 3'd7, 5'd31, 1'b0);
        send0(1'b0, 4'hF, 32'h99, 32'h98, 3'd7, 5'd31, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        send1(1'b0, 4'h0, 32'h0, 32'h0, 3'd0, 5'd0, 1'b0);
        @(negedge CLK);
        chk("T1 out_valid", pay_t'(out_valid), '0);
        chk("T1 out_ctrl", pay_t'(out_ctrl), '0);
        chk("T1 out_alu", pay_t'(out_alu), '0);
        chk("T1 in_ready", pay_t'(in_ready), pay_t'(1'b1));
        chk("T1 noskid in_ready", pay_t'(s0_in_ready), pay_t'(1'b1));
        @(posedge CLK);
        #1;

        // T2: streaming with out_ready=1, no gaps
        out_ready = 1'b1;
        send1(1'b1, 4'b1010, 32'h10, 32'h100, 3'd2, 5'd1, 1'b1); cyc1("T2 c1", 1'b1, 1'b0);
        send1(1'b1, 4'b1001, 32'h14, 32'h104, 3'd0, 5'd2, 1'b1); cyc1("T2 c2", 1'b1, 1'b1);
        send1(1'b1, 4'b1100, 32'h18, 32'h108, 3'd4, 5'd3, 1'b1); cyc1("T2 c3", 1'b1, 1'b1);
        send1(1'b0, 4'b0000, 32'h0, 32'h0, 3'd0, 5'd0, 1'b0);    cyc1("T2 c4", 1'b1, 1'b1);

        // T3: fill both entries under stall, then drain in order
        out_ready = 1'b0;
        send1(1'b1, 4'b0110, 32'hA, 32'hAA, 3'd1, 5'd10, 1'b1); cyc1("T3 A", 1'b1, 1'b0);
        send1(1'b1, 4'b0101, 32'hB, 32'hBB, 3'd5, 5'd11, 1'b1); cyc1("T3 B", 1'b1, 1'b1);
        send1(1'b1, 4'b1111, 32'hC, 32'hCC, 3'd6, 5'd12, 1'b0); cyc1("T3 C held", 1'b0, 1'b1);
        cyc1("T3 C held2", 1'b0, 1'b1);
        out_ready = 1'b1;
        send1(1'b0, 4'b0000, 32'h0, 32'h0, 3'd0, 5'd0, 1'b0);
        cyc1("T3 drain A", 1'b0, 1'b1);
        cyc1("T3 drain B", 1'b1, 1'b1);
        cyc1("T3 empty", 1'b1, 1'b0);

        // T4: flush while full (in_valid high), then flush with a same-cycle accept
        out_ready = 1'b0;
        send1(1'b1, 4'b1011, 32'h2A, 32'h2AA, 3'd2, 5'd20, 1'b1); cyc1("T4 A", 1'b1, 1'b0);
        send1(1'b1, 4'b1101, 32'h2B, 32'h2BB, 3'd3, 5'd21, 1'b1); cyc1("T4 B", 1'b1, 1'b1);
        FLUSH = 1'b1;
        send1(1'b1, 4'b1111, 32'h2C, 32'h2CC, 3'd4, 5'd22, 1'b0); cyc1("T4 flush full", 1'b0, 1'b1);
        q1.delete();
        FLUSH = 1'b0; out_ready = 1'b1;
        send1(1'b0, 4'b0000, 32'h0, 32'h0, 3'd0, 5'd0, 1'b0);
        @(negedge CLK);
        chk("T4 out_ctrl after flush", pay_t'(out_ctrl), '0);
        cyc1("T4 after flush", 1'b1, 1'b0);
        out_ready = 1'b0;
        send1(1'b1, 4'b0011, 32'h3D, 32'h3DD, 3'd1, 5'd23, 1'b1); cyc1("T4 D", 1'b1, 1'b0);
        FLUSH = 1'b1;
        send1(1'b1, 4'b1110, 32'h3E, 32'h3EE, 3'd2, 5'd24, 1'b0); cyc1("T4 flush accept", 1'b1, 1'b1);
        q1.delete();
        FLUSH = 1'b0; out_ready = 1'b1;
        send1(1'b0, 4'b0000, 32'h0, 32'h0, 3'd0, 5'd0, 1'b0);
        cyc1("T4 killed", 1'b1, 1'b0);
        send1(1'b1, 4'b1000, 32'h3F, 32'h3FF, 3'd5, 5'd25, 1'b1); cyc1("T4 F", 1'b1, 1'b0);
        send1(1'b0, 4'b0000, 32'h0, 32'h0, 3'd0, 5'd0, 1'b0);    cyc1("T4 F out", 1'b1, 1'b1);

        // T5: bubbles with all control bits high on the input
        send1(1'b0, 4'b1111, 32'h55, 32'h66, 3'd7, 5'd30, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("T5 bubble out_ctrl", pay_t'(out_ctrl), '0);
            cyc1("T5 bubble", 1'b1, 1'b0);
        end

        // T6: SKID=0 combinational ready
        s0_out_ready = 1'b0;
        send0(1'b1, 4'b1010, 32'h50, 32'h500, 3'd2, 5'd3, 1'b1); cyc0("T6 fill", 1'b1, 1'b0);
        send0(1'b1, 4'b0101, 32'h60, 32'h600, 3'd1, 5'd4, 1'b0); cyc0("T6 stall", 1'b0, 1'b1);
        s0_out_ready = 1'b1;
        send0(1'b1, 4'b1001, 32'h70, 32'h700, 3'd0, 5'd7, 1'b1); cyc0("T6 swap", 1'b1, 1'b1);
        chk("T6 out_rd", pay_t'(s0_out_rd), pay_t'(5'd7));
        send0(1'b0, 4'b0000, 32'h0, 32'h0, 3'd0, 5'd0, 1'b0);    cyc0("T6 rd7 out", 1'b1, 1'b1);
        cyc0("T6 empty", 1'b1, 1'b0);

        repeat (2) @(posedge CLK);
        #1;
        chk("skid queue drained", pay_t'(q1.size()), '0);
        chk("noskid queue drained", pay_t'(q0.size()), '0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
